// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - drives all 16 abcd combinations, samples f after a settle window,
// and returns the truth table with popcount and first-mismatch index over a valid/ready handshake.
module truth_table_scanner #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        check_en,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        tt_valid,
  input  logic        tt_ready,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count,
  output logic        mismatch,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  ones_q, ones_d;
  logic        mis_q, mis_d;
  logic [3:0]  ffi_q, ffi_d;
  logic [15:0] exp_q, exp_d;
  logic        chk_q, chk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 16'd0;
      ones_q  <= 5'd0;
      mis_q   <= 1'b0;
      ffi_q   <= 4'd0;
      exp_q   <= 16'd0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      mis_q   <= mis_d;
      ffi_q   <= ffi_d;
      exp_q   <= exp_d;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    mis_d   = mis_q;
    ffi_d   = ffi_q;
    exp_d   = exp_q;
    chk_d   = chk_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = 4'd0;
          cnt_d   = RELOAD;
          tt_d    = 16'd0;
          ones_d  = 5'd0;
          mis_d   = 1'b0;
          ffi_d   = 4'd0;
          exp_d   = expected;
          chk_d   = check_en;
        end
      end
      SCAN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Ascending scan order means the first recorded failure is the lowest index.
          tt_d[idx_q] = f_in;
          ones_d      = ones_q + {4'd0, f_in};
          if (chk_q && (f_in != exp_q[idx_q]) && !mis_q) begin
            mis_d = 1'b1;
            ffi_d = idx_q;
          end
          if (idx_q == 4'd15) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
            cnt_d = RELOAD;
          end
        end
      end
      DONE: begin
        if (tt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign abcd           = idx_q;
  assign busy           = (state_q != IDLE);
  assign tt_valid       = (state_q == DONE);
  assign truth_table    = tt_q;
  assign ones_count     = ones_q;
  assign mismatch       = mis_q;
  assign first_fail_idx = ffi_q;

endmodule
